// File: rtl/lcm_pkg.sv
// Shared definitions for the sequential LCM unit: default operand width,
// FSM state type and a helper sizing the per-phase cycle counter.
package lcm_pkg;

  // Default operand width in bits.
  localparam int LCM_W_DEFAULT = 16;

  // Top-level FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GCD  = 3'd1,
    ST_DIV  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } lcm_state_e;

  // Width of a counter that must reach w-1 (never narrower than one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/lcm_unit_seq_gcd.sv
// gcd_seq_core: subtractive GCD engine. A start pulse loads the operand pair;
// each following cycle performs one swap or subtract step, and done pulses
// (with gcd valid) in the cycle B reaches zero, after which the core is idle.
module gcd_seq_core
  import lcm_pkg::*;
#(
  parameter int W = LCM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         done,
  output logic [W-1:0] gcd
);

  logic         busy_q, busy_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;

  // Operand registers and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  // One GCD step per cycle: swap so A>=B, subtract while B!=0, finish on B==0.
  always_comb begin
    busy_d = busy_q;
    a_d    = a_q;
    b_d    = b_q;
    done   = 1'b0;
    if (!busy_q) begin
      if (start) begin
        a_d    = a_in;
        b_d    = b_in;
        busy_d = 1'b1;
      end
    end else if (a_q < b_q) begin
      a_d = b_q;
      b_d = a_q;
    end else if (b_q != '0) begin
      a_d = a_q - b_q;
    end else begin
      done   = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign gcd = a_q;

endmodule

// File: rtl/lcm_unit_seq.sv
// lcm_unit_seq: sequential least-common-multiple unit.
// lcm(a,b) = (a / gcd(a,b)) * b, computed as: subtractive GCD (gcd_seq_core),
// W-cycle restoring division, then W-cycle shift-add multiply into 2W bits.
// A zero operand short-circuits straight to a result of 0.
// Optional build macro LCM_UNIT_GCD_OUT_EN adds the out_gcd output port.
module lcm_unit_seq
  import lcm_pkg::*;
#(
  parameter int W = LCM_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_val,
  output logic           in_rdy,
  input  logic [W-1:0]   inA,
  input  logic [W-1:0]   inB,
  output logic           out_val,
  input  logic           out_rdy,
  output logic [2*W-1:0] out
`ifdef LCM_UNIT_GCD_OUT_EN
  ,
  output logic [W-1:0]   out_gcd
`endif
);

  localparam int CW = cnt_width(W);

  lcm_state_e     state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;    // captured first operand (dividend)
  logic [W-1:0]   op_b_q, op_b_d;    // captured second operand (multiplicand)
  logic [W-1:0]   g_q, g_d;          // gcd, 0 for a zero operand
  logic [W-1:0]   rem_q, rem_d;      // division partial remainder
  logic [W-1:0]   quo_q, quo_d;      // quotient during DIV, shifting multiplier during MUL
  logic [CW-1:0]  cnt_q, cnt_d;      // bit counter for DIV and MUL phases
  logic [2*W-1:0] acc_q, acc_d;      // product accumulator
  logic [2*W-1:0] mcand_q, mcand_d;  // left-shifting multiplicand
  logic [2*W-1:0] out_q, out_d;      // result register, held between transactions

  logic           gcd_start;
  logic           gcd_done;
  logic [W-1:0]   gcd_val;

  // Division / multiplication step values.
  logic [W:0]     div_t;
  logic [W:0]     div_sub;
  logic           div_ge;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;
  logic [2*W-1:0] acc_step;
  logic           last_cnt;

  gcd_seq_core #(.W(W)) u_gcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (gcd_start),
    .a_in  (inA),
    .b_in  (inB),
    .done  (gcd_done),
    .gcd   (gcd_val)
  );

  // State and datapath registers; reset clears everything and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      g_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      g_q     <= g_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      out_q   <= out_d;
    end
  end

  // Per-cycle arithmetic: one restoring-division bit and one shift-add bit.
  always_comb begin
    div_t    = {rem_q, quo_q[W-1]};
    div_sub  = div_t - {1'b0, g_q};
    div_ge   = (div_t >= {1'b0, g_q});
    rem_step = div_ge ? div_sub[W-1:0] : div_t[W-1:0];
    quo_step = (quo_q << 1) | {{(W-1){1'b0}}, div_ge};
    acc_step = acc_q + (quo_q[0] ? mcand_q : '0);
    last_cnt = (cnt_q == CW'(W - 1));
  end

  // Next-state and datapath control for the IDLE/GCD/DIV/MUL/DONE sequence.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    g_d       = g_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    out_d     = out_q;
    gcd_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // in_rdy is high throughout IDLE, so in_val alone completes the accept.
        if (in_val) begin
          op_a_d = inA;
          op_b_d = inB;
          if (inA == '0 || inB == '0) begin
            out_d   = '0;
            g_d     = '0;
            state_d = ST_DONE;
          end else begin
            // The GCD core loads inA/inB on this same edge.
            gcd_start = 1'b1;
            state_d   = ST_GCD;
          end
        end
      end

      ST_GCD: begin
        if (gcd_done) begin
          g_d     = gcd_val;
          rem_d   = '0;
          quo_d   = op_a_q;
          cnt_d   = '0;
          state_d = ST_DIV;
        end
      end

      ST_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (last_cnt) begin
          // quo_step now holds opA/g exactly; it becomes the multiplier.
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = {{W{1'b0}}, op_b_q};
          state_d = ST_MUL;
        end
      end

      ST_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        quo_d   = quo_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_cnt) begin
          cnt_d   = '0;
          out_d   = acc_step;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_rdy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_rdy  = (state_q == ST_IDLE);
  assign out_val = (state_q == ST_DONE);
  assign out     = out_q;

`ifdef LCM_UNIT_GCD_OUT_EN
  // g_q is only written on accept or GCD completion, so it is stable in DONE.
  assign out_gcd = g_q;
`else
  // Without the gcd port, g_q serves only as the divisor.
`endif

endmodule

// File: doc/lcm_unit_seq.md
LCM_UNIT_SEQ -- requirements
Module: lcm_unit_seq

Interface
REQ-001 SHALL have parameter W, default 16: operand width in bits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_val, input, 1: operand pair valid.
REQ-005 SHALL have port in_rdy, output, 1: unit can accept an operand pair.
REQ-006 SHALL have port inA, input, W: first operand, unsigned.
REQ-007 SHALL have port inB, input, W: second operand, unsigned.
REQ-008 SHALL have port out_val, output, 1: result valid.
REQ-009 SHALL have port out_rdy, input, 1: consumer accepts the result.
REQ-010 SHALL have port out, output, 2W: least common multiple of the accepted pair, unsigned.

Function
REQ-011 SHALL run the FSM states IDLE, GCD, DIV, MUL and DONE.
REQ-012 SHALL, in IDLE, hold in_rdy=1 and, on in_val&in_rdy, capture inA and inB into opA and opB.
REQ-013 SHALL, on that capture, go to DONE with out=0 when inA==0 or inB==0, and go to GCD otherwise.
REQ-014 SHALL, in GCD, perform one step per cycle: if A<B then swap A and B; else if B!=0 then A=A-B; else g=A and go to DIV.
REQ-015 SHALL, in DIV, compute q=opA/g by restoring division in exactly W cycles, then go to MUL; the remainder is always 0.
REQ-016 SHALL, in MUL, compute out=q*opB by shift-add in exactly W cycles with a 2W-bit accumulator (no overflow possible), then go to DONE.
REQ-017 SHALL, in DONE, hold out_val=1 and out stable until out_rdy=1, then return to IDLE in the next cycle.
REQ-018 SHALL hold in_rdy=0 in every state except IDLE, and ignore in_val there.
REQ-019 SHALL not assert in_rdy in the handoff cycle itself: a result and a new operand pair cannot be accepted in the same cycle.
REQ-020 SHALL keep out at its last value when out_val=0 (the value is don't-care for consumers).
REQ-021 SHALL accept one pair per transaction, with latency from accept to out_val = 1 + (GCD steps + 1) + 2W cycles (zero-operand case: 1 cycle).

Reset
REQ-022 SHALL, on rst_n=0, immediately force the state to IDLE, in_rdy=1, out_val=0, out=0, and all datapath registers to 0.
REQ-023 SHALL, on reset asserted mid-operation, discard the operation with no result emitted, and accept a new pair normally after release.

Configuration
REQ-024 SHALL, with macro LCM_UNIT_GCD_OUT_EN defined, add output port out_gcd [W-1:0], valid with out_val, holding g (0 when an operand is 0).
REQ-025 SHALL, without LCM_UNIT_GCD_OUT_EN, have no out_gcd port and identical behaviour otherwise.

Structure
REQ-026 SHALL use package lcm_pkg to hold the FSM state enum type and the default width constant.
REQ-027 SHALL implement the subtractive GCD loop as sub-module gcd_seq_core (start/done handshake, W-bit A/B registers).
REQ-028 SHALL keep the division and multiplication datapath in lcm_unit_seq.

Verification
REQ-029 SHALL pass: (12,18) -> out=36 (out_gcd=6), out_val 1+GCD steps+1+32 cycles after accept.
REQ-030 SHALL pass: (0,5) and (5,0) -> out=0 one cycle after accept, with no DIV/MUL cycles.
REQ-031 SHALL pass: (65535,65534) -> out=4294770690, gcd=1.
REQ-032 SHALL pass: (7,7) -> out=7; with out_rdy held low 5 cycles, out_val and out are stable, in_rdy=0, and in_val pulses are ignored.
REQ-033 SHALL pass: rst_n pulsed low during MUL of (12,18) -> out_val=0 and in_rdy=1 immediately; next pair (4,6) -> out=12.
REQ-034 SHALL pass: back-to-back pairs with in_val held high -> each pair is accepted only in IDLE, and the results arrive in order.
